fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the 128-point radix-2^2 SDF FFT. The FFT emits each frame in bit-reversed order. This block accepts that stream and re-emits each frame in natural bin order (bin 0..N-1) as one contiguous 128-cycle burst, tagged with the bin index and a last-bin flag. It sits directly on the FFT do_en/do_re/do_im outputs, ahead of the spectral (de)scrambling logic in the receive path.

---
 rtl/fft_bitrev_reorder.sv | 87 ++++++++
 tb/tb_fft_bitrev_reorder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns bit-reversed FFT frames into natural-order output bursts
module fft_bitrev_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG2N-1:0] do_idx,
    output logic             do_last
);
    localparam int N = 1 << LOG2N;
    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = a[LOG2N-1-i];
    endfunction

    logic [2*WIDTH-1:0] mem [2*N];
    state_t             state_q, state_d;
    logic [LOG2N-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, idx_q, idx_d;
    logic               wbank_q, wbank_d, rbank_q, rbank_d, en_q, en_d, last_q, last_d;
    logic [1:0]         full_q, full_d;
    logic [2*WIDTH-1:0] dat_q, dat_d;
    logic               rd, rd_end, wr_end;

    // Banks fill and drain in the same alternating order, so rbank always points at the older full bank.
    always_comb begin
        rd      = state_q == READ;
        rd_end  = rd && rcnt_q == '1;
        wr_end  = di_en && wcnt_q == '1;
        wcnt_d  = di_en ? wcnt_q + 1'b1 : wcnt_q;
        wbank_d = wbank_q ^ wr_end;
        rbank_d = rbank_q ^ rd_end;
        full_d  = full_q;
        if (rd_end) full_d[rbank_q] = 1'b0;
        if (wr_end) full_d[wbank_q] = 1'b1;
        rcnt_d  = rd ? rcnt_q + 1'b1 : '0;
        state_d = rd ? ((rd_end && !full_q[~rbank_q]) ? IDLE : READ)
                     : (full_q[rbank_q] ? READ : IDLE);
        en_d    = rd;
        idx_d   = rcnt_q;
        last_d  = rd_end;
        dat_d   = rd ? mem[{rbank_q, rcnt_q}] : '0;
    end

    always_ff @(posedge clock) begin
        if (di_en) mem[{wbank_q, bitrev(wcnt_q)}] <= {di_re, di_im};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            idx_q   <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            en_q    <= en_d;
            last_q  <= last_d;
            dat_q   <= dat_d;
        end
    end

    assign do_en   = en_q;
    assign do_re   = dat_q[2*WIDTH-1:WIDTH];
    assign do_im   = dat_q[WIDTH-1:0];
    assign do_idx  = idx_q;
    assign do_last = last_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: randomized frames checked against a frame-level reorder model with output timing
module tb_fft_bitrev_reorder;
    localparam int N = 128;
    logic        clock = 1'b0, reset = 1'b1, di_en = 1'b0;
    logic [15:0] di_re = '0, di_im = '0, do_re, do_im;
    logic        do_en, do_last;
    logic [6:0]  do_idx;
    int          checks = 0, failures = 0, cyc = 0, pcnt = 0, last_end = -1000;
    logic [31:0] part [N];
    typedef struct {int cyc; logic [15:0] re; logic [15:0] im; int idx;} exp_t;
    exp_t        q[$];

    fft_bitrev_reorder #(.WIDTH(16), .LOG2N(7)) dut (
        .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
        .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_idx(do_idx), .do_last(do_last)
    );

    always #5 clock = ~clock;

    function automatic int rev(input int k);
        int r = 0;
        for (int i = 0; i < 7; i++) begin
            r = r * 2 + k % 2;
            k = k / 2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then check outputs at the falling edge.
    task automatic tick();
        exp_t e;
        int   start;
        bit   rst_edge;
        @(posedge clock);
        cyc++;
        rst_edge = reset;
        if (reset) begin
            q.delete();
            pcnt = 0;
            last_end = -1000;
        end else if (di_en) begin
            part[pcnt] = {di_re, di_im};
            pcnt++;
            if (pcnt == N) begin
                start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
                for (int b = 0; b < N; b++) begin
                    e.cyc = start + b;
                    {e.re, e.im} = part[rev(b)];
                    e.idx = b;
                    q.push_back(e);
                end
                last_end = start + N - 1;
                pcnt = 0;
            end
        end
        @(negedge clock);
        if (rst_edge) begin
            check("rst_en", 32'(do_en), 0);
            check("rst_re", 32'(do_re), 0);
            check("rst_im", 32'(do_im), 0);
            check("rst_idx", 32'(do_idx), 0);
            check("rst_last", 32'(do_last), 0);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            check("en", 32'(do_en), 1);
            check("re", 32'(do_re), 32'(q[0].re));
            check("im", 32'(do_im), 32'(q[0].im));
            check("idx", 32'(do_idx), q[0].idx);
            check("last", 32'(do_last), 32'(q[0].idx == N - 1));
            void'(q.pop_front());
        end else begin
            check("idle_en", 32'(do_en), 0);
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im);
        di_en = 1'b1;
        di_re = re;
        di_im = im;
        tick();
        di_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain();
        int i = 0;
        while (q.size() > 0 && i < 1000) begin
            tick();
            i++;
        end
        check("drain_timeout", q.size(), 0);
        idle(3);
    endtask

    initial begin
        bit found = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(2);
        for (int k = 0; k < N; k++) send(16'(rev(k)), 16'(0));
        drain();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < N; k++) send(16'(256 * f + rev(k)), 16'($urandom));
        drain();
        for (int k = 0; k < N; k++) begin
            send(16'($urandom), 16'($urandom));
            idle(2);
        end
        drain();
        for (int k = 0; k < 60; k++) send(16'($urandom), 16'($urandom));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N; k++) send(16'($urandom), 16'($urandom));
        drain();
        for (int k = 0; k < N; k++) send(16'($urandom), 16'($urandom));
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            found = do_en && do_idx == 7'd50;
        end
        check("idx50_seen", 32'(found), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(300);
        for (int k = 0; k < N; k++) send(16'h8000, 16'h7fff);
        for (int k = 0; k < N; k++) send(k % 2 ? 16'haaaa : 16'h5555, k % 2 ? 16'h5555 : 16'haaaa);
        drain();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < N; k++) begin
                send(16'($urandom), 16'($urandom));
                if ($urandom_range(3) == 0) idle($urandom_range(4, 1));
            end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
